// File: rtl/mw_cook_sequencer.sv
// Microwave cook sequencer: keypad/button edge detection, cook FSM, 1 Hz prescaler
// and done-hold timer. All outputs are registered next to the state register.
module mw_cook_sequencer #(
    parameter int TICK_DIV    = 100,
    parameter int DONE_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] kbd,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       time_zero,
    output logic       shift_en,
    output logic [3:0] shift_digit,
    output logic       dec_en,
    output logic       clr_en,
    output logic       mag_on,
    output logic       done,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [9:0]    r_kbd_q;
    logic          r_startn_q;
    logic          r_stopn_q;
    logic [2:0]    r_state;
    logic [1:0]    r_digit_cnt;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_done_cnt;
    logic          r_shift_en;
    logic [3:0]    r_shift_digit;
    logic          r_dec_en;
    logic          r_clr_en;
    logic          r_mag_on;
    logic          r_done;

    logic          w_onehot;
    logic          w_key;
    logic          w_start;
    logic          w_stop;
    logic          w_can_cook;
    logic [3:0]    w_digit;
    logic [2:0]    w_nstate;
    logic [1:0]    w_ncnt;
    logic [PW-1:0] w_npresc;
    logic [DW-1:0] w_ndone_cnt;
    logic          w_nshift;
    logic          w_ndec;
    logic          w_nclr;

    // Multi-bit keypad patterns never count as a press.
    assign w_onehot   = (kbd != '0) && ((kbd & (kbd - 10'd1)) == '0);
    assign w_key      = w_onehot && (r_kbd_q == '0);
    assign w_start    = r_startn_q & ~startn;
    assign w_stop     = r_stopn_q & ~stopn;
    assign w_can_cook = door_closed & ~time_zero;

    always_comb begin
        w_digit = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (kbd[i]) w_digit = 4'(i);
        end
    end

    always_comb begin
        w_nstate    = r_state;
        w_ncnt      = r_digit_cnt;
        w_npresc    = '0;
        w_ndone_cnt = '0;
        w_nshift    = 1'b0;
        w_ndec      = 1'b0;
        w_nclr      = 1'b0;
        if (!clearn) begin
            w_nstate = S_IDLE;
            w_nclr   = 1'b1;
            w_ncnt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_key) begin
                        w_nstate = S_SET;
                        w_nshift = 1'b1;
                        w_ncnt   = 2'd1;
                    end
                end
                S_SET: begin
                    if (w_stop) begin
                        w_nstate = S_IDLE;
                        w_nclr   = 1'b1;
                        w_ncnt   = '0;
                    end else if (w_start && w_can_cook) begin
                        w_nstate = S_COOK;
                    end else if (w_key && r_digit_cnt < 2'd3) begin
                        w_nshift = 1'b1;
                        w_ncnt   = r_digit_cnt + 2'd1;
                    end
                end
                S_COOK: begin
                    if (!door_closed || w_stop) begin
                        w_nstate = S_PAUSE;
                    end else if (time_zero) begin
                        w_nstate = S_DONE;
                    end else if (r_presc == PW'(TICK_DIV - 1)) begin
                        w_ndec = 1'b1;
                    end else begin
                        w_npresc = r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (w_stop) begin
                        w_nstate = S_IDLE;
                        w_nclr   = 1'b1;
                        w_ncnt   = '0;
                    end else if (w_start && w_can_cook) begin
                        w_nstate = S_COOK;
                    end
                end
                S_DONE: begin
                    if (r_done_cnt == DW'(DONE_CYCLES - 1)) begin
                        w_nstate = S_IDLE;
                        w_ncnt   = '0;
                    end else begin
                        w_ndone_cnt = r_done_cnt + DW'(1);
                    end
                end
                default: w_nstate = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kbd_q       <= '0;
            r_startn_q    <= 1'b1;
            r_stopn_q     <= 1'b1;
            r_state       <= S_IDLE;
            r_digit_cnt   <= '0;
            r_presc       <= '0;
            r_done_cnt    <= '0;
            r_shift_en    <= 1'b0;
            r_shift_digit <= '0;
            r_dec_en      <= 1'b0;
            r_clr_en      <= 1'b0;
            r_mag_on      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_kbd_q       <= kbd;
            r_startn_q    <= startn;
            r_stopn_q     <= stopn;
            r_state       <= w_nstate;
            r_digit_cnt   <= w_ncnt;
            r_presc       <= w_npresc;
            r_done_cnt    <= w_ndone_cnt;
            r_shift_en    <= w_nshift;
            r_shift_digit <= w_nshift ? w_digit : r_shift_digit;
            r_dec_en      <= w_ndec;
            r_clr_en      <= w_nclr;
            r_mag_on      <= (w_nstate == S_COOK);
            r_done        <= (w_nstate == S_DONE);
        end
    end

    assign shift_en    = r_shift_en;
    assign shift_digit = r_shift_digit;
    assign dec_en      = r_dec_en;
    assign clr_en      = r_clr_en;
    assign mag_on      = r_mag_on;
    assign done        = r_done;
    assign state       = r_state;

endmodule

// File: doc/mw_cook_sequencer.md
# mw_cook_sequencer

Control FSM for the microwave's mm:ss BCD countdown datapath. Turns keypad presses into digit-shift commands and start/stop/clear/door events into load, decrement and clear strobes, and gates the magnetron. Contains the 1 Hz tick prescaler. Sits between the keypad/button inputs and the countdown register that feeds the seven-segment decoders.

## Interface
- TICK_DIV, 100: clk cycles per countdown second (100 at the 10 ms bench clock)
- DONE_CYCLES, 200: cycles `done` stays high after cook completes
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- kbd  in  10  one-hot keypad, bit i = digit i; synchronous, debounced upstream
- startn / stopn / clearn  in  1 each  active-low buttons, synchronous
- door_closed  in  1  1 = door shut
- time_zero  in  1  from datapath: count is 00:00
- shift_en  out  1  one-cycle strobe: datapath shifts `shift_digit` into the seconds-ones position
- shift_digit  out  4  binary digit 0-9, valid with `shift_en`
- dec_en  out  1  one-cycle strobe: datapath decrements by one second
- clr_en  out  1  one-cycle strobe: datapath clears to 00:00
- mag_on  out  1  magnetron enable
- done  out  1  cook-complete indicator
- state  out  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4

## Operation
- Edge detection: kbd, startn and stopn are registered once. A key press is a cycle where kbd is exactly one-hot and kbd_q == 0. Any other kbd value starts no new press, so multi-bit patterns are ignored. A start or stop press is a 1→0 transition. clearn is level-sensitive.
- Priority, highest first: clear, door-open, stop, start, key.
- clearn == 0 in any state:
  - go to IDLE
  - pulse clr_en
  - reset the digit counter
  - drop mag_on and done
- IDLE:
  - key press → SET, pulse shift_en, digit_cnt = 1
  - start and stop are ignored
- SET:
  - key press with digit_cnt < 3: pulse shift_en, digit_cnt++
  - 4th and later presses are ignored
  - start with door_closed = 1 and time_zero = 0 → COOK
  - start with the door open or time_zero = 1: no effect
  - stop → IDLE with clr_en
- COOK:
  - mag_on = 1
  - The prescaler counts 0..TICK_DIV-1 and clears on every COOK entry. At terminal count with time_zero = 0, pulse dec_en.
  - time_zero = 1 → DONE
  - stop press, or door_closed = 0 → PAUSE
  - keys are ignored
- PAUSE:
  - mag_on = 0
  - start with the door closed and time_zero = 0 → COOK
  - stop → IDLE with clr_en
  - keys are ignored
- DONE:
  - done = 1, mag_on = 0
  - A counter runs DONE_CYCLES cycles, then → IDLE. The datapath is already 00:00, so no clr_en.
  - keys and start are ignored; clear exits early
- digit_cnt is a 2-bit saturating counter. It is cleared on IDLE entry.

## Timing
- Reset values:
  - state = IDLE
  - all strobes = 0; mag_on = 0; done = 0
  - prescaler and counters = 0
  - edge registers: kbd_q = 0, startn_q = 1, stopn_q = 1
  - rst does not pulse clr_en; the datapath shares rst.
- All outputs are registered.
- A press sampled at edge N produces its strobe and state change visible after edge N+1 (one-cycle latency).
- Strobe width is exactly one cycle.
- mag_on follows state == COOK in the same cycle, since it is registered with the state.
- First dec_en comes TICK_DIV cycles after the COOK entry cycle, then every TICK_DIV cycles.
- A remaining partial second is discarded on PAUSE; resume restarts a full TICK_DIV period.
- time_zero rises one cycle after the final dec_en. COOK→DONE follows on the next edge, so mag_on falls two cycles after the last dec_en.
- Simultaneous events:
  - stop and start in the same cycle: stop wins
  - door opening and stop in the same cycle in COOK: PAUSE, with a single transition
  - a key held across a clear is not re-shifted until it is released

## Test plan
- Reset, keys 1 then 2, then start, TICK_DIV = 100, datapath model from 00:12 → exactly 12 dec_en pulses 100 cycles apart; COOK→DONE; done high for 200 cycles; then IDLE.
- Keys 1, 2, 9, 5 → exactly 3 shift_en pulses with digits 1, 2, 9; the 5 is ignored; state = SET.
- Start keyed 3-5 (00:35), stop press after 5 s → PAUSE, mag_on = 0, count = 00:30. Second stop → IDLE with one clr_en.
- Cooking 1:29, door_closed = 0 for 100 cycles → PAUSE, no dec_en while open. Close door then start → COOK, next dec_en 100 cycles later.
- kbd = 10'b0000000110 held, then 0, then 10'b0000000100 → only one shift_en, digit 2. Start with time_zero = 1 → remains SET, mag_on = 0.
- clearn low in mid-COOK, and rst asserted mid-COOK → both IDLE within one edge (rst: immediately). clr_en pulses only for clearn. Outputs match the reset values.
